// File: rtl/adc_code_averager.sv
// Averages each 2^LOG2_N-sample window of aligned ADC codes with round-half-up,
// after discarding SKIP warm-up samples; results leave on a valid/ready port.
//
// state  | meaning
// WARMUP | discarding strobed samples while the alignment pipeline fills
// ACCUM  | summing samples into the current window
module adc_code_averager #(
  parameter int DATA_W = 6,
  parameter int LOG2_N = 2,
  parameter int SKIP   = 2
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              en_i,
  input  logic [DATA_W-1:0] code_i,
  input  logic              clear_i,
  input  logic              ready_i,
  output logic [DATA_W-1:0] avg_o,
  output logic              valid_o,
  output logic              overrun_o,
  output logic              busy_o
);

  localparam int                ACC_W     = DATA_W + LOG2_N;
  localparam logic [LOG2_N-1:0] CNT_LAST  = '1;
  localparam logic [3:0]        SKIP_LAST = (SKIP > 0) ? 4'(SKIP - 1) : 4'd0;
  localparam logic [ACC_W-1:0]  HALF      = ACC_W'(2 ** (LOG2_N - 1));

  typedef enum logic {WARMUP, ACCUM} state_t;

  // With no samples to skip the block starts out ready to accumulate.
  localparam state_t RESET_STATE = (SKIP == 0) ? ACCUM : WARMUP;

  state_t            state_q, state_d;
  logic [3:0]        skip_cnt_q;
  logic [LOG2_N-1:0] sample_cnt_q;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  sum_w;
  logic              accept;
  logic              complete;

  assign accept   = en_i && !clear_i && (state_q == ACCUM);
  assign complete = accept && (sample_cnt_q == CNT_LAST);
  // Sum cannot exceed 2^ACC_W-1: at most N*(2^DATA_W-1) + N/2.
  assign sum_w    = acc_q + ACC_W'(code_i) + HALF;
  assign busy_o   = (state_q == ACCUM) && (sample_cnt_q != '0);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = ACCUM;
    end else if ((state_q == WARMUP) && en_i && (skip_cnt_q == SKIP_LAST)) begin
      state_d = ACCUM;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      skip_cnt_q <= '0;
    end else if (!clear_i && (state_q == WARMUP) && en_i) begin
      skip_cnt_q <= skip_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      acc_q        <= '0;
      sample_cnt_q <= '0;
    end else if (clear_i || complete) begin
      acc_q        <= '0;
      sample_cnt_q <= '0;
    end else if (accept) begin
      acc_q        <= acc_q + ACC_W'(code_i);
      sample_cnt_q <= sample_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      avg_o     <= '0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else if (clear_i) begin
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else if (complete) begin
      if (valid_o && !ready_i) begin
        overrun_o <= 1'b1;
      end else begin
        avg_o   <= sum_w[ACC_W-1:LOG2_N];
        valid_o <= 1'b1;
      end
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_code_averager.sv
// Directed bench for adc_code_averager with default parameters
// (DATA_W=6, LOG2_N=2, SKIP=2); expected averages are hand-computed.
module tb_adc_code_averager;

  logic       clk_i = 1'b0;
  logic       reset_ni;
  logic       en_i;
  logic [5:0] code_i;
  logic       clear_i;
  logic       ready_i;
  logic [5:0] avg_o;
  logic       valid_o;
  logic       overrun_o;
  logic       busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  adc_code_averager #(.DATA_W(6), .LOG2_N(2), .SKIP(2)) dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .en_i     (en_i),
    .code_i   (code_i),
    .clear_i  (clear_i),
    .ready_i  (ready_i),
    .avg_o    (avg_o),
    .valid_o  (valid_o),
    .overrun_o(overrun_o),
    .busy_o   (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic send(input int code);
    @(negedge clk_i);
    en_i   = 1'b1;
    code_i = 6'(code);
    @(negedge clk_i);
    en_i   = 1'b0;
  endtask

  task automatic consume();
    @(negedge clk_i);
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
    check("consume_valid", int'(valid_o), 0);
  endtask

  task automatic window(input string tag, input int a, input int b, input int c,
                        input int d, input int expected);
    send(a);
    send(b);
    send(c);
    send(d);
    check({tag, "_avg"}, int'(avg_o), expected);
    check({tag, "_valid"}, int'(valid_o), 1);
  endtask

  initial begin
    reset_ni = 1'b0;
    en_i     = 1'b0;
    code_i   = '0;
    clear_i  = 1'b0;
    ready_i  = 1'b0;
    #12;
    check("rst_avg", int'(avg_o), 0);
    check("rst_valid", int'(valid_o), 0);
    check("rst_overrun", int'(overrun_o), 0);
    check("rst_busy", int'(busy_o), 0);
    @(negedge clk_i);
    reset_ni = 1'b1;

    // Warm-up discard
    send(10);
    send(20);
    check("warm_valid", int'(valid_o), 0);
    check("warm_busy", int'(busy_o), 0);
    send(1);
    send(2);
    send(3);
    check("w1_partial_valid", int'(valid_o), 0);
    check("w1_partial_busy", int'(busy_o), 1);
    send(4);
    check("w1_avg", int'(avg_o), 3);
    check("w1_valid", int'(valid_o), 1);
    check("w1_busy", int'(busy_o), 0);
    consume();

    // Rounding and full scale
    window("r1112", 1, 1, 1, 2, 1);
    consume();
    window("r1222", 1, 2, 2, 2, 2);
    consume();
    window("r63", 63, 63, 63, 63, 63);
    consume();
    window("r0001", 0, 0, 0, 1, 0);
    consume();

    // Back-pressure and overrun
    window("bp5", 5, 5, 5, 5, 5);
    check("bp5_overrun", int'(overrun_o), 0);
    window("bp9", 9, 9, 9, 9, 5);
    check("bp9_overrun", int'(overrun_o), 1);
    consume();
    check("bp_overrun_sticky", int'(overrun_o), 1);
    @(negedge clk_i);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    check("clr_overrun", int'(overrun_o), 0);
    check("clr_avg_hold", int'(avg_o), 5);

    // Transfer and completion on the same edge
    window("sim5", 5, 5, 5, 5, 5);
    send(7);
    send(7);
    send(7);
    @(negedge clk_i);
    en_i    = 1'b1;
    code_i  = 6'd7;
    ready_i = 1'b1;
    @(negedge clk_i);
    en_i    = 1'b0;
    ready_i = 1'b0;
    check("sim7_avg", int'(avg_o), 7);
    check("sim7_valid", int'(valid_o), 1);
    check("sim7_overrun", int'(overrun_o), 0);
    consume();

    // Gapped strobes, then clear together with a strobe
    send(4);
    repeat (3) @(negedge clk_i);
    send(4);
    check("gap_busy", int'(busy_o), 1);
    @(negedge clk_i);
    clear_i = 1'b1;
    en_i    = 1'b1;
    code_i  = 6'd60;
    @(negedge clk_i);
    clear_i = 1'b0;
    en_i    = 1'b0;
    check("gap_clr_busy", int'(busy_o), 0);
    check("gap_clr_valid", int'(valid_o), 0);
    window("w8", 8, 8, 8, 8, 8);
    consume();

    // Asynchronous reset mid-window
    send(1);
    send(1);
    send(1);
    check("pre_rst_busy", int'(busy_o), 1);
    #1;
    reset_ni = 1'b0;
    #1;
    check("arst_avg", int'(avg_o), 0);
    check("arst_valid", int'(valid_o), 0);
    check("arst_busy", int'(busy_o), 0);
    check("arst_overrun", int'(overrun_o), 0);
    #1;
    reset_ni = 1'b1;
    send(30);
    send(40);
    check("rewarm_busy", int'(busy_o), 0);
    check("rewarm_valid", int'(valid_o), 0);
    window("post_rst", 2, 2, 2, 2, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/adc_code_averager.md
Name: adc_code_averager

Overview:
- Downstream consumer of the 2-stage time-alignment register. Takes the aligned 6-bit {MSB,LSB} conversion code once per sample strobe.
- Discards the first SKIP samples after reset, while the alignment pipeline still holds invalid codes.
- Averages each window of 2^LOG2_N samples with round-half-up.
- Presents each result on a valid/ready output with a sticky overrun flag. Output feeds the readout/serializer logic.

Parameters:
- DATA_W, 6, width of input code and average output
- LOG2_N, 2, log2 of window length; legal range 1..6
- SKIP, 2, strobed samples discarded after reset before the first window; legal range 0..15

Ports:
- clk_i  input  1  system clock, all logic on rising edge
- reset_ni  input  1  asynchronous reset, active-low
- en_i  input  1  sample strobe; code_i is consumed on every rising edge with en_i=1
- code_i  input  DATA_W  aligned conversion code from the time-alignment stage
- clear_i  input  1  synchronous clear of the partial window and flags
- ready_i  input  1  downstream accepts avg_o when valid_o=1
- avg_o  output  DATA_W  rounded window average
- valid_o  output  1  avg_o holds an unconsumed result
- overrun_o  output  1  sticky: a completed window was dropped
- busy_o  output  1  high in ACCUM with at least one sample in the current window

Behaviour:
- Reset (reset_ni=0, asynchronous):
  - state=WARMUP, skip count=0, sample count=0, accumulator=0.
  - avg_o=0, valid_o=0, overrun_o=0, busy_o=0.
  - Reset mid-window loses the partial sum; no result is emitted.
- States:
  - WARMUP: each en_i increments the skip count. Move to ACCUM on the edge that consumes sample SKIP. With SKIP=0, enter ACCUM directly out of reset.
  - ACCUM: each en_i adds code_i to the accumulator (width DATA_W+LOG2_N, cannot overflow) and increments the sample count.
- Window completion: occurs on the en_i edge that consumes sample 2^LOG2_N.
  - Result = (acc + code_i + 2^(LOG2_N-1)) >> LOG2_N, truncated to DATA_W bits. The maximum is exactly 2^DATA_W-1, so no saturation is needed.
  - On that same edge the accumulator and count reset to 0, so the next sample starts a new window with no bubble.
  - Latency: avg_o/valid_o update on the edge consuming the last sample, i.e. visible one cycle after it is presented.
- Output handshake:
  - Transfer occurs on any edge with valid_o=1 and ready_i=1.
  - valid_o falls after a transfer unless a new window completes on the same edge.
  - avg_o is stable while valid_o=1 and ready_i=0.
  - ready_i is ignored while valid_o=0.
- Completion with valid_o=1, ready_i=0: the new result is dropped, avg_o keeps the old value, overrun_o is set and stays 1 until clear_i or reset.
- Completion with valid_o=1, ready_i=1 on the same edge: the old result transfers, the new result loads, valid_o stays 1, no overrun.
- en_i=0 cycles: accumulator and counts hold; gaps inside a window are allowed.
- clear_i=1 has priority over en_i and ready_i. On that edge:
  - accumulator and sample count cleared; valid_o=0; overrun_o=0; avg_o holds its last value.
  - state becomes ACCUM. Warm-up is not repeated.
  - Any en_i sample on the same edge is discarded.
- busy_o is combinational from state and count.

Test Plan:
- Warm-up discard: SKIP=2, LOG2_N=2. en_i pulses with codes 10, 20, then 1, 2, 3, 4 -> 10 and 20 ignored; avg_o=3 (sum 10 +2 >>2), valid_o=1 one cycle after code 4; no valid_o earlier.
- Rounding and full scale:
  - window 1, 1, 1, 2 -> avg_o=1
  - window 1, 2, 2, 2 -> avg_o=2
  - window 63, 63, 63, 63 -> avg_o=63
  - window 0, 0, 0, 1 -> avg_o=0
- Back-pressure / overrun: ready_i=0; windows averaging 5 then 9 -> avg_o stays 5, valid_o=1, overrun_o=1 after the second window. Then ready_i=1 for one cycle -> valid_o=0, overrun_o remains 1 until a clear_i pulse.
- Simultaneous transfer and completion: valid_o=1 (avg_o=5), ready_i=1 on the edge completing window 7, 7, 7, 7 -> avg_o=7, valid_o stays 1, overrun_o=0.
- Gapped strobes and clear:
  - codes 4, 4 with idle cycles between, then clear_i=1 together with en_i (code 60) -> window restarts, 60 discarded.
  - next 8, 8, 8, 8 -> avg_o=8.
- Reset mid-operation: after 3 of 4 samples (warmed up), pulse reset_ni low asynchronously between edges -> all outputs 0 immediately.
  - The next 2 strobes are skipped again; the following 4 samples 2, 2, 2, 2 -> avg_o=2.
